// File: rtl/ptw_port_arbiter_if.sv
// rtl/ptw_port_arbiter_if.sv - page-walk request/response port shared by TLB and MMU sides
// master drives the request level and receives the one-cycle response strobe.
interface ptw_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int PERM_W = 8
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [ADDR_W-1:0] resp_addr;
  logic [PERM_W-1:0] resp_perm;

  modport master (output req_valid, req_addr, input resp_valid, resp_addr, resp_perm);
  modport slave  (input req_valid, req_addr, output resp_valid, resp_addr, resp_perm);
endinterface

// File: rtl/ptw_port_arbiter.sv
// rtl/ptw_port_arbiter.sv - round-robin arbiter sharing one MMU page-walk port between I-TLB and D-TLB
// Grants one walk at a time, routes the response to the owner only, counts walks per port.
module ptw_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  ptw_port_arbiter_if.slave  itlb,
  ptw_port_arbiter_if.slave  dtlb,
  ptw_port_arbiter_if.master mmu,
  output logic [CNT_W-1:0]   itlb_walks,
  output logic [CNT_W-1:0]   dtlb_walks
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              walk_valid, walk_valid_nxt;
  logic [ADDR_W-1:0] walk_addr, walk_addr_nxt;
  logic              last_d, last_d_nxt;
  logic [CNT_W-1:0]  icnt_nxt, dcnt_nxt;
  logic              grant_d, i_resp, d_resp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      walk_valid <= 1'b0;
      walk_addr  <= '0;
      last_d     <= 1'b0;
      itlb_walks <= '0;
      dtlb_walks <= '0;
    end else begin
      state      <= state_nxt;
      walk_valid <= walk_valid_nxt;
      walk_addr  <= walk_addr_nxt;
      last_d     <= last_d_nxt;
      itlb_walks <= icnt_nxt;
      dtlb_walks <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    walk_valid_nxt = walk_valid;
    walk_addr_nxt  = walk_addr;
    last_d_nxt     = last_d;
    icnt_nxt       = itlb_walks;
    dcnt_nxt       = dtlb_walks;
    grant_d        = 1'b0;
    i_resp         = 1'b0;
    d_resp         = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        grant_d = dtlb.req_valid && (!itlb.req_valid || !last_d);
        if (grant_d) begin
          state_nxt      = BUSY_D;
          walk_valid_nxt = 1'b1;
          walk_addr_nxt  = dtlb.req_addr;
          last_d_nxt     = 1'b1;
          if (!(&dtlb_walks)) dcnt_nxt = dtlb_walks + CNT_W'(1);
        end else if (itlb.req_valid) begin
          state_nxt      = BUSY_I;
          walk_valid_nxt = 1'b1;
          walk_addr_nxt  = itlb.req_addr;
          last_d_nxt     = 1'b0;
          if (!(&itlb_walks)) icnt_nxt = itlb_walks + CNT_W'(1);
        end
      end
      BUSY_I: begin
        if (mmu.resp_valid) begin
          i_resp         = itlb.req_valid;
          walk_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end else if (!itlb.req_valid) begin
          state_nxt = DRAIN;
        end
      end
      BUSY_D: begin
        if (mmu.resp_valid) begin
          d_resp         = dtlb.req_valid;
          walk_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end else if (!dtlb.req_valid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mmu.resp_valid) begin
          walk_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
    endcase
  end

  assign mmu.req_valid   = walk_valid;
  assign mmu.req_addr    = walk_addr;
  assign itlb.resp_valid = i_resp && !reset;
  assign dtlb.resp_valid = d_resp && !reset;
  assign itlb.resp_addr  = mmu.resp_addr;
  assign itlb.resp_perm  = mmu.resp_perm;
  assign dtlb.resp_addr  = mmu.resp_addr;
  assign dtlb.resp_perm  = mmu.resp_perm;

  // A completion with no walk outstanding is an MMU protocol error.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE) assert (!mmu.resp_valid);
  end
endmodule

// File: tb/tb_ptw_port_arbiter.sv
// tb/tb_ptw_port_arbiter.sv - self-checking bench for ptw_port_arbiter
// Directed scenarios plus a randomized run against a transaction-level owner/round-robin model.
module tb_ptw_port_arbiter;
  localparam int ADDR_W = 64;
  localparam int PERM_W = 8;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] itlb_walks;
  logic [CNT_W-1:0] dtlb_walks;
  int               passed;
  int               total;

  ptw_port_arbiter_if #(.ADDR_W(ADDR_W), .PERM_W(PERM_W)) i_bus ();
  ptw_port_arbiter_if #(.ADDR_W(ADDR_W), .PERM_W(PERM_W)) d_bus ();
  ptw_port_arbiter_if #(.ADDR_W(ADDR_W), .PERM_W(PERM_W)) m_bus ();

  ptw_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .itlb       (i_bus),
    .dtlb       (d_bus),
    .mmu        (m_bus),
    .itlb_walks (itlb_walks),
    .dtlb_walks (dtlb_walks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_bus.req_valid  = 1'b0;
    i_bus.req_addr   = '0;
    d_bus.req_valid  = 1'b0;
    d_bus.req_addr   = '0;
    m_bus.resp_valid = 1'b0;
    m_bus.resp_addr  = '0;
    m_bus.resp_perm  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    i_bus.req_valid = 1'b1;
    i_bus.req_addr  = 64'h1234;
    cyc();
    cyc();
    total++; if (m_bus.req_valid !== 1'b0) $display("FAIL reset_req_valid got=%0b exp=0", m_bus.req_valid); else passed++;
    total++; if (m_bus.req_addr !== '0) $display("FAIL reset_req_addr got=%0h exp=0", m_bus.req_addr); else passed++;
    total++; if (itlb_walks !== '0 || dtlb_walks !== '0) $display("FAIL reset_walks got=%0d/%0d exp=0/0", itlb_walks, dtlb_walks); else passed++;
    total++; if (i_bus.resp_valid !== 1'b0 || d_bus.resp_valid !== 1'b0) $display("FAIL reset_resp got=%0b%0b exp=00", i_bus.resp_valid, d_bus.resp_valid); else passed++;
    clear_inputs();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_i_only();
    do_reset();
    i_bus.req_valid = 1'b1;
    i_bus.req_addr  = 64'h4000_1000;
    #1;
    total++; if (m_bus.req_valid !== 1'b0) $display("FAIL ionly_no_early_req got=%0b exp=0", m_bus.req_valid); else passed++;
    cyc();
    total++; if (m_bus.req_valid !== 1'b1 || m_bus.req_addr !== 64'h4000_1000) $display("FAIL ionly_req got=%0b/%0h exp=1/40001000", m_bus.req_valid, m_bus.req_addr); else passed++;
    total++; if (itlb_walks !== CNT_W'(1)) $display("FAIL ionly_walks got=%0d exp=1", itlb_walks); else passed++;
    cyc();
    cyc();
    m_bus.resp_valid = 1'b1;
    m_bus.resp_addr  = 64'h8_0000_1000;
    m_bus.resp_perm  = 8'h5b;
    #1;
    total++; if (i_bus.resp_valid !== 1'b1 || d_bus.resp_valid !== 1'b0) $display("FAIL ionly_resp got=%0b%0b exp=10", i_bus.resp_valid, d_bus.resp_valid); else passed++;
    total++; if (i_bus.resp_addr !== 64'h8_0000_1000 || i_bus.resp_perm !== 8'h5b) $display("FAIL ionly_resp_data got=%0h/%0h exp=800001000/5b", i_bus.resp_addr, i_bus.resp_perm); else passed++;
    cyc();
    m_bus.resp_valid = 1'b0;
    i_bus.req_valid  = 1'b0;
    #1;
    total++; if (i_bus.resp_valid !== 1'b0 || m_bus.req_valid !== 1'b0) $display("FAIL ionly_done got=%0b/%0b exp=0/0", i_bus.resp_valid, m_bus.req_valid); else passed++;
  endtask

  task automatic test_tie_alternation();
    logic [63:0] ia [2];
    logic [63:0] da [2];
    ia[0] = 64'h1111_0000; ia[1] = 64'h1111_8000;
    da[0] = 64'h2222_0000; da[1] = 64'h2222_8000;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      i_bus.req_valid = 1'b1; i_bus.req_addr = ia[r];
      d_bus.req_valid = 1'b1; d_bus.req_addr = da[r];
      cyc();
      total++; if (m_bus.req_valid !== 1'b1 || m_bus.req_addr !== da[r]) $display("FAIL tie_first_d round=%0d got=%0b/%0h exp=1/%0h", r, m_bus.req_valid, m_bus.req_addr, da[r]); else passed++;
      m_bus.resp_valid = 1'b1; m_bus.resp_addr = 64'habc0 + 64'(r);
      #1;
      total++; if (d_bus.resp_valid !== 1'b1 || i_bus.resp_valid !== 1'b0) $display("FAIL tie_d_resp round=%0d got=%0b%0b exp=01", r, i_bus.resp_valid, d_bus.resp_valid); else passed++;
      cyc();
      m_bus.resp_valid = 1'b0; d_bus.req_valid = 1'b0;
      #1;
      total++; if (m_bus.req_valid !== 1'b0) $display("FAIL tie_gap1 round=%0d got=%0b exp=0", r, m_bus.req_valid); else passed++;
      cyc();
      total++; if (m_bus.req_valid !== 1'b1 || m_bus.req_addr !== ia[r]) $display("FAIL tie_then_i round=%0d got=%0b/%0h exp=1/%0h", r, m_bus.req_valid, m_bus.req_addr, ia[r]); else passed++;
      m_bus.resp_valid = 1'b1;
      #1;
      total++; if (i_bus.resp_valid !== 1'b1 || d_bus.resp_valid !== 1'b0) $display("FAIL tie_i_resp round=%0d got=%0b%0b exp=10", r, i_bus.resp_valid, d_bus.resp_valid); else passed++;
      cyc();
      m_bus.resp_valid = 1'b0; i_bus.req_valid = 1'b0;
      #1;
      total++; if (m_bus.req_valid !== 1'b0) $display("FAIL tie_gap2 round=%0d got=%0b exp=0", r, m_bus.req_valid); else passed++;
    end
    total++; if (itlb_walks !== CNT_W'(2) || dtlb_walks !== CNT_W'(2)) $display("FAIL tie_walks got=%0d/%0d exp=2/2", itlb_walks, dtlb_walks); else passed++;
  endtask

  task automatic test_wait_mid_walk();
    do_reset();
    d_bus.req_valid = 1'b1; d_bus.req_addr = 64'hd000;
    cyc();
    i_bus.req_valid = 1'b1; i_bus.req_addr = 64'h1000;
    cyc();
    total++; if (m_bus.req_addr !== 64'hd000 || i_bus.resp_valid !== 1'b0) $display("FAIL wait_hold got=%0h/%0b exp=d000/0", m_bus.req_addr, i_bus.resp_valid); else passed++;
    m_bus.resp_valid = 1'b1;
    #1;
    total++; if (d_bus.resp_valid !== 1'b1 || i_bus.resp_valid !== 1'b0) $display("FAIL wait_d_only got=%0b%0b exp=01", i_bus.resp_valid, d_bus.resp_valid); else passed++;
    cyc();
    m_bus.resp_valid = 1'b0; d_bus.req_valid = 1'b0;
    #1;
    total++; if (m_bus.req_valid !== 1'b0) $display("FAIL wait_idle got=%0b exp=0", m_bus.req_valid); else passed++;
    cyc();
    total++; if (m_bus.req_valid !== 1'b1 || m_bus.req_addr !== 64'h1000) $display("FAIL wait_i_grant got=%0b/%0h exp=1/1000", m_bus.req_valid, m_bus.req_addr); else passed++;
    m_bus.resp_valid = 1'b1;
    cyc();
    m_bus.resp_valid = 1'b0; i_bus.req_valid = 1'b0;
  endtask

  task automatic test_abandon();
    do_reset();
    d_bus.req_valid = 1'b1; d_bus.req_addr = 64'hdd00;
    cyc();
    total++; if (m_bus.req_valid !== 1'b1) $display("FAIL abandon_start got=%0b exp=1", m_bus.req_valid); else passed++;
    cyc();
    d_bus.req_valid = 1'b0;
    i_bus.req_valid = 1'b1; i_bus.req_addr = 64'h1100;
    cyc();
    total++; if (m_bus.req_valid !== 1'b1 || m_bus.req_addr !== 64'hdd00) $display("FAIL abandon_hold got=%0b/%0h exp=1/dd00", m_bus.req_valid, m_bus.req_addr); else passed++;
    m_bus.resp_valid = 1'b1;
    #1;
    total++; if (d_bus.resp_valid !== 1'b0 || i_bus.resp_valid !== 1'b0) $display("FAIL abandon_swallow got=%0b%0b exp=00", i_bus.resp_valid, d_bus.resp_valid); else passed++;
    cyc();
    m_bus.resp_valid = 1'b0;
    #1;
    total++; if (m_bus.req_valid !== 1'b0 || dtlb_walks !== CNT_W'(1)) $display("FAIL abandon_idle got=%0b/%0d exp=0/1", m_bus.req_valid, dtlb_walks); else passed++;
    cyc();
    total++; if (m_bus.req_valid !== 1'b1 || m_bus.req_addr !== 64'h1100) $display("FAIL abandon_next_i got=%0b/%0h exp=1/1100", m_bus.req_valid, m_bus.req_addr); else passed++;
    m_bus.resp_valid = 1'b1;
    #1;
    total++; if (i_bus.resp_valid !== 1'b1) $display("FAIL abandon_i_resp got=%0b exp=1", i_bus.resp_valid); else passed++;
    cyc();
    m_bus.resp_valid = 1'b0; i_bus.req_valid = 1'b0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    i_bus.req_valid = 1'b1; i_bus.req_addr = 64'h7700;
    cyc();
    total++; if (m_bus.req_valid !== 1'b1) $display("FAIL rbusy_start got=%0b exp=1", m_bus.req_valid); else passed++;
    reset = 1'b1;
    m_bus.resp_valid = 1'b1;
    #1;
    total++; if (i_bus.resp_valid !== 1'b0) $display("FAIL rbusy_no_strobe got=%0b exp=0", i_bus.resp_valid); else passed++;
    cyc();
    m_bus.resp_valid = 1'b0; i_bus.req_valid = 1'b0; reset = 1'b0;
    #1;
    total++; if (m_bus.req_valid !== 1'b0 || itlb_walks !== '0) $display("FAIL rbusy_idle got=%0b/%0d exp=0/0", m_bus.req_valid, itlb_walks); else passed++;
    cyc();
    total++; if (m_bus.req_valid !== 1'b0) $display("FAIL rbusy_stay_idle got=%0b exp=0", m_bus.req_valid); else passed++;
  endtask

  task automatic test_saturation();
    bit seen;
    int exp_cnt;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      seen = 1'b0;
      cyc();
      i_bus.req_valid = 1'b1; i_bus.req_addr = 64'h1000 * 64'(k);
      for (int w = 0; w < 8 && !seen; w++) begin
        cyc();
        if (m_bus.req_valid === 1'b1) seen = 1'b1;
      end
      total++; if (!seen) $display("FAIL sat_grant_timeout walk=%0d got=0 exp=1", k); else passed++;
      if (seen) m_bus.resp_valid = 1'b1;
      cyc();
      m_bus.resp_valid = 1'b0; i_bus.req_valid = 1'b0;
      #1;
      exp_cnt = (k > CMAX) ? CMAX : k;
      total++; if (itlb_walks !== CNT_W'(exp_cnt)) $display("FAIL sat_count walk=%0d got=%0d exp=%0d", k, itlb_walks, exp_cnt); else passed++;
    end
  endtask

  task automatic test_random();
    int          owner;
    bit          last_d;
    logic [63:0] addr_q;
    int          icnt, dcnt;
    bit          i_act, d_act, i_done, d_done;
    logic [63:0] ia, da;
    bit          armed, responded, resp;
    int          cd;
    logic [63:0] pa;
    logic [7:0]  pp;
    bit          exp_i, exp_d;
    do_reset();
    owner = 0; last_d = 1'b0; addr_q = '0; icnt = 0; dcnt = 0;
    i_act = 1'b0; d_act = 1'b0; i_done = 1'b0; d_done = 1'b0;
    ia = '0; da = '0; armed = 1'b0; responded = 1'b0; cd = 0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) cyc();
      if (i_done) i_act = 1'b0;
      else if (!i_act && $urandom_range(0, 2) == 0) begin i_act = 1'b1; ia = {$urandom, $urandom}; end
      if (d_done) d_act = 1'b0;
      else if (!d_act && $urandom_range(0, 2) == 0) begin d_act = 1'b1; da = {$urandom, $urandom}; end
      i_bus.req_valid = i_act; i_bus.req_addr = ia;
      d_bus.req_valid = d_act; d_bus.req_addr = da;
      resp = 1'b0;
      if (m_bus.req_valid !== 1'b1) begin
        armed = 1'b0; responded = 1'b0;
      end else begin
        if (!armed) begin armed = 1'b1; cd = $urandom_range(0, 3); end
        if (!responded) begin
          if (cd == 0) begin resp = 1'b1; responded = 1'b1; end
          else cd--;
        end
      end
      pa = {$urandom, $urandom}; pp = 8'($urandom);
      m_bus.resp_valid = resp; m_bus.resp_addr = pa; m_bus.resp_perm = pp;
      #1;
      exp_i = resp && owner == 1;
      exp_d = resp && owner == 2;
      total++; if (m_bus.req_valid !== (owner != 0)) $display("FAIL rnd_req_valid cyc=%0d got=%0b exp=%0b", c, m_bus.req_valid, owner != 0); else passed++;
      if (owner != 0) begin
        total++; if (m_bus.req_addr !== addr_q) $display("FAIL rnd_req_addr cyc=%0d got=%0h exp=%0h", c, m_bus.req_addr, addr_q); else passed++;
      end
      total++; if (i_bus.resp_valid !== exp_i || d_bus.resp_valid !== exp_d) $display("FAIL rnd_resp_route cyc=%0d got=%0b%0b exp=%0b%0b", c, i_bus.resp_valid, d_bus.resp_valid, exp_i, exp_d); else passed++;
      if (exp_i) begin
        total++; if (i_bus.resp_addr !== pa || i_bus.resp_perm !== pp) $display("FAIL rnd_i_data cyc=%0d got=%0h/%0h exp=%0h/%0h", c, i_bus.resp_addr, i_bus.resp_perm, pa, pp); else passed++;
      end
      if (exp_d) begin
        total++; if (d_bus.resp_addr !== pa || d_bus.resp_perm !== pp) $display("FAIL rnd_d_data cyc=%0d got=%0h/%0h exp=%0h/%0h", c, d_bus.resp_addr, d_bus.resp_perm, pa, pp); else passed++;
      end
      total++; if (itlb_walks !== CNT_W'(icnt) || dtlb_walks !== CNT_W'(dcnt)) $display("FAIL rnd_walks cyc=%0d got=%0d/%0d exp=%0d/%0d", c, itlb_walks, dtlb_walks, icnt, dcnt); else passed++;
      i_done = exp_i;
      d_done = exp_d;
      if (owner != 0) begin
        if (resp) owner = 0;
      end else if (d_act && (!i_act || !last_d)) begin
        owner = 2; addr_q = da; last_d = 1'b1;
        if (dcnt < CMAX) dcnt++;
      end else if (i_act) begin
        owner = 1; addr_q = ia; last_d = 1'b0;
        if (icnt < CMAX) icnt++;
      end
    end
    cyc();
    clear_inputs();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_i_only();
    test_tie_alternation();
    test_wait_mid_walk();
    test_abandon();
    test_reset_busy();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
